// File: rtl/regfile_writeback_queue.sv
// Register-file writeback queue: buffers producer results, drains them through a
// shared RF write port, and forwards the youngest pending value to two readers.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_waddr,
  output logic [DW-1:0]              rf_wdata,
  input  logic                       rf_grant,
  input  logic [AW-1:0]              fwd_addr1,
  input  logic [AW-1:0]              fwd_addr2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [DW-1:0]              fwd_data1,
  output logic [DW-1:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  assign in_ready = (count_q < CW'(DEPTH)) && !reset && !flush;
  // Writes to r0 complete the handshake but are never stored.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign rf_we    = (count_q != '0) && !flush && !reset;
  assign pop      = rf_we && rf_grant;
  assign rf_waddr = addr_mem[head_q];
  assign rf_wdata = data_mem[head_q];
  assign count    = reset ? '0 : count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (reset || flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= in_addr;
      data_mem[tail_q] <= in_data;
    end
  end

  logic [1:0][AW-1:0] fwd_addr_v;
  logic [1:0]         fwd_hit_v;
  logic [1:0][DW-1:0] fwd_data_v;

  assign fwd_addr_v = {fwd_addr2, fwd_addr1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [PW-1:0] idx;
      logic          hit;
      logic [DW-1:0] data;

      // Walk oldest to youngest so the last match (closest to tail) wins.
      always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
          idx = head_q + PW'(i);
          if ((CW'(i) < count_q) && (addr_mem[idx] == fwd_addr_v[gi])) begin
            hit  = 1'b1;
            data = data_mem[idx];
          end
        end
        if (reset || flush || (fwd_addr_v[gi] == '0)) begin
          hit  = 1'b0;
          data = '0;
        end
      end

      assign fwd_hit_v[gi]  = hit;
      assign fwd_data_v[gi] = data;
    end
  endgenerate

  assign fwd_hit1  = fwd_hit_v[0];
  assign fwd_hit2  = fwd_hit_v[1];
  assign fwd_data1 = fwd_data_v[0];
  assign fwd_data2 = fwd_data_v[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: a queue model of pending writes
// predicts count, handshakes, drain order and forwarding every cycle.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, in_ready, rf_we, rf_grant;
  logic          fwd_hit1, fwd_hit2;
  logic [AW-1:0] in_addr, rf_waddr, fwd_addr1, fwd_addr2;
  logic [DW-1:0] in_data, rf_wdata, fwd_data1, fwd_data2;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_grant(rf_grant),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic fwd_model(input logic [AW-1:0] fa, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (!reset && !flush && fa != '0) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].a == fa) begin
          hit = 1'b1;
          d   = sb[i].d;
          break;
        end
      end
    end
  endtask

  // Inputs are stable from posedge+1; outputs are checked at the negedge and the
  // model is advanced at the following posedge.
  task automatic tick();
    logic          eh;
    logic [DW-1:0] ed;
    ent_t          e;
    bit            ready_e, we_e;
    @(negedge clk);
    ready_e = !reset && !flush && (sb.size() < DEPTH);
    we_e    = !reset && !flush && (sb.size() != 0);
    check_eq("count", 64'(count), reset ? 64'd0 : 64'(sb.size()));
    check_eq("in_ready", 64'(in_ready), 64'(ready_e));
    check_eq("rf_we", 64'(rf_we), 64'(we_e));
    fwd_model(fwd_addr1, eh, ed);
    check_eq("fwd_hit1", 64'(fwd_hit1), 64'(eh));
    check_eq("fwd_data1", 64'(fwd_data1), 64'(ed));
    fwd_model(fwd_addr2, eh, ed);
    check_eq("fwd_hit2", 64'(fwd_hit2), 64'(eh));
    check_eq("fwd_data2", 64'(fwd_data2), 64'(ed));
    if (we_e) begin
      e = sb[0];
      check_eq("rf_waddr", 64'(rf_waddr), 64'(e.a));
      check_eq("rf_wdata", 64'(rf_wdata), 64'(e.d));
      if (rf_grant) begin
        void'(sb.pop_front());
        $display("[TB] writeback r%0d <= %08h", e.a, e.d);
      end
    end
    @(posedge clk);
    if (reset || flush) sb.delete();
    else if (in_valid && ready_e && in_addr != '0) sb.push_back({in_addr, in_data});
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic g);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    rf_grant = g;
    tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_grant = 1'b0; fwd_addr1 = '0; fwd_addr2 = '0;
    repeat (2) tick();
    reset = 1'b0;

    // single write, granted immediately
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b1);

    // fill while stalled, 5th request refused, then drain in order
    for (int i = 1; i <= 4; i++) drive(1'b1, AW'(i), DW'(i * 32'h100), 1'b0);
    drive(1'b1, 5'd5, 32'h500, 1'b0);
    repeat (5) drive(1'b0, 5'd0, 32'h0, 1'b1);

    // youngest-match forwarding
    fwd_addr1 = 5'd5; fwd_addr2 = 5'd6;
    drive(1'b1, 5'd5, 32'h11, 1'b0);
    drive(1'b1, 5'd5, 32'h22, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    repeat (3) drive(1'b0, 5'd0, 32'h0, 1'b1);

    // writes to r0 are swallowed
    fwd_addr1 = 5'd0;
    drive(1'b1, 5'd0, 32'h1234, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b1);

    // flush a full queue with a competing request
    fwd_addr1 = 5'd2; fwd_addr2 = 5'd4;
    for (int i = 1; i <= 4; i++) drive(1'b1, AW'(i), 32'hA000 + i, 1'b0);
    flush = 1'b1;
    drive(1'b1, 5'd7, 32'h7777, 1'b1);
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1);

    // reset mid-operation
    for (int i = 1; i <= 3; i++) drive(1'b1, AW'(i + 10), 32'hB000 + i, 1'b0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1);

    // pointer wrap with occupancy held at one
    drive(1'b1, 5'd9, 32'hC000, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, AW'(10 + i), 32'hC100 + i, 1'b1);
    repeat (2) drive(1'b0, 5'd0, 32'h0, 1'b1);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      fwd_addr1 = AW'($urandom_range(0, 7));
      fwd_addr2 = AW'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
    end
    reset = 1'b0; flush = 1'b0;
    repeat (DEPTH + 1) drive(1'b0, 5'd0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter DW, default 32, register data width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous discard of all pending entries.
REQ-007 SHALL have port in_valid  input  1  result-producer write request.
REQ-008 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-009 SHALL have port in_addr  input  AW  destination register.
REQ-010 SHALL have port in_data  input  DW  write value.
REQ-011 SHALL have port rf_we  output  1  register-file write enable (head entry valid).
REQ-012 SHALL have port rf_waddr  output  AW  head entry address.
REQ-013 SHALL have port rf_wdata  output  DW  head entry data.
REQ-014 SHALL have port rf_grant  input  1  register-file write port available this cycle.
REQ-015 SHALL have ports fwd_addr1/fwd_addr2  input  AW  read addresses to check against pending writes.
REQ-016 SHALL have ports fwd_hit1/fwd_hit2  output  1  pending write exists for that address.
REQ-017 SHALL have ports fwd_data1/fwd_data2  output  DW  youngest pending value for that address.
REQ-018 SHALL have port count  output  $clog2(DEPTH)+1  number of pending entries.

Function
REQ-019 SHALL implement a circular FIFO of DEPTH entries {addr, data} with head/tail pointers wrapping modulo DEPTH.
REQ-020 SHALL drive in_ready = 1 when count < DEPTH and reset = 0 and flush = 0; in_ready SHALL NOT depend on same-cycle dequeue.
REQ-021 SHALL accept (handshake) when in_valid & in_ready; accepted entry written at tail, tail and count advance at next edge.
REQ-022 SHALL discard accepted requests with in_addr = 0 (handshake completes, nothing queued, count unchanged).
REQ-023 SHALL drive rf_we = (count != 0) & ~flush, rf_waddr/rf_wdata = head entry contents, combinationally from stored state.
REQ-024 SHALL dequeue head when rf_we & rf_grant; head advances, count decrements at next edge.
REQ-025 SHALL, on simultaneous accept and dequeue, keep count unchanged and advance both pointers.
REQ-026 SHALL have one-cycle minimum latency: request accepted at edge N appears on rf_we from cycle after edge N.
REQ-027 SHALL hold rf_waddr/rf_wdata stable while rf_we = 1 and rf_grant = 0.
REQ-028 SHALL compute fwd_hitK/fwd_dataK combinationally over all valid entries, selecting the youngest (closest to tail) matching entry; the head entry being dequeued this cycle SHALL still count.
REQ-029 SHALL drive fwd_hitK = 0 and fwd_dataK = 0 when fwd_addrK = 0, when no valid entry matches, or while flush = 1.
REQ-030 SHALL ignore in_valid and rf_grant while flush = 1; at the next edge count = 0 and head = tail = 0.
REQ-031 SHALL give reset priority over flush, flush over enqueue/dequeue.

Reset
REQ-032 SHALL, while reset = 1, drive in_ready = 0, rf_we = 0, fwd_hit1/2 = 0, fwd_data1/2 = 0, count = 0.
REQ-033 SHALL, at the edge with reset = 1, clear count, head and tail to 0; entry storage need not be cleared.
REQ-034 SHALL, when reset asserts mid-operation, discard all pending entries; no rf_we asserted until a new request is accepted.
REQ-035 SHALL drive in_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-036 SHALL cover: reset, enqueue (addr 3, 0xDEADBEEF), rf_grant = 1 -> rf_we = 1 with addr 3, data 0xDEADBEEF next cycle; count 1 then 0.
REQ-037 SHALL cover: rf_grant = 0, enqueue 4 writes (addrs 1,2,3,4) -> count = 4, in_ready = 0; 5th in_valid not accepted; then rf_grant = 1 drains in order 1,2,3,4 over 4 cycles.
REQ-038 SHALL cover: queue {r5 = 0x11, r5 = 0x22}, fwd_addr1 = 5 -> fwd_hit1 = 1, fwd_data1 = 0x22; fwd_addr2 = 6 -> fwd_hit2 = 0, fwd_data2 = 0.
REQ-039 SHALL cover: enqueue addr 0, data 0x1234 -> in_ready handshake completes, count stays 0, rf_we stays 0, fwd_addr1 = 0 -> fwd_hit1 = 0.
REQ-040 SHALL cover: full queue, same cycle flush = 1 and in_valid = 1 -> no accept, rf_we = 0 during flush; next cycle count = 0, in_ready = 1.
REQ-041 SHALL cover: count = 3 then reset for 1 cycle -> count = 0, rf_we = 0, in_ready = 0 during reset, in_ready = 1 after; pointer wrap exercised by 10 back-to-back enqueue/dequeue pairs with count constant at 1.
